program_counter: RTL and testbench
==================================

// Module: program_counter
// PURPOSE
//  Fetch-side program counter feeding instruction memory. Its outputs are decoded into Type/RTypeOP/ITypeOP/ImmediateIn for the ALU.
//  Consumes the ALU's ConditionalBranch and the 5-bit immediate field as a branch-target LUT index.
//  Sequences program start, linear fetch, absolute branches via a loadable target LUT, and halt/done.
// PARAMETERS
//  PC_WIDTH    10   width of ProgCtr; instruction memory depth = 2**PC_WIDTH
//  LUT_DEPTH   32   branch-target LUT entries; indexed by 5-bit Target
// PORTS
//  Clk          in   1         single clock, all state on posedge
//  Reset        in   1         synchronous, active-high; overrides every other input
//  Start        in   1         request program run from address 0
//  Halt         in   1         decoder flags halt instruction at current ProgCtr
//  Branch       in   1         ALU ConditionalBranch for instruction at current ProgCtr
//  Target       in   5         LUT index (instruction immediate field)
//  LutWe        in   1         write enable for branch-target LUT
//  LutAddr      in   5         LUT write address
//  LutData      in   PC_WIDTH  LUT write data (absolute target address)
//  ProgCtr      out  PC_WIDTH  current fetch address
//  FetchEn      out  1         high when ProgCtr is a valid instruction to execute
//  Done         out  1         program finished (HALT state)
//  BranchCount  out  16        taken-branch count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, ProgCtr=0, FetchEn=0, Done=0, BranchCount=0; LUT contents = 0.
//  Reset asserted mid-run: aborts on the next edge; no further increments.
//  States: IDLE -> RUN on Start; RUN -> HALT on Halt; HALT -> RUN on Start; any -> IDLE on Reset.
//  IDLE: ProgCtr held at 0, FetchEn=0, Done=0; Halt/Branch ignored.
//  Start in IDLE/HALT: next cycle state=RUN, ProgCtr=0, FetchEn=1, Done=0.
//  Start in RUN: ignored (no restart).
//  RUN, per edge, priority high->low:
//    Halt=1 -> state=HALT, ProgCtr holds, FetchEn=0, Done=1 next cycle.
//    Branch=1 -> ProgCtr = LUT[Target] next cycle.
//    else -> ProgCtr = ProgCtr+1 mod 2**PC_WIDTH.
//  Wrap-around: ProgCtr at all-ones increments to 0; this is not an error and not a halt.
//  Latency: Branch sampled at cycle n is reflected in ProgCtr at n+1; no delay slot, no bubble.
//  HALT: ProgCtr, Done=1, FetchEn=0 held until Start or Reset; Branch/Halt ignored.
//  LUT write: any state. LutWe at edge n writes LUT[LutAddr]=LutData, visible from n+1.
//  Same-cycle write and branch to the same index uses the OLD entry.
//  Target/LutAddr >= LUT_DEPTH: reads return 0; writes are dropped.
//  Halt and Branch together: Halt wins; branch is not taken and not counted.
// CONFIGURATION
//  Macro PC_BRANCH_COUNT_EN.
//  Defined:
//    BranchCount increments by 1 on every taken branch in RUN.
//    Saturates at 16'hFFFF.
//    Cleared to 0 on Reset and on the edge where Start launches a run.
//  Undefined: BranchCount tied to 16'h0000; no counter flops.
// TESTING
//  1 Reset=1 2 cycles, then Reset=0 -> ProgCtr=0, FetchEn=0, Done=0, BranchCount=0.
//  2 Start pulse, no Branch/Halt for 5 cycles -> ProgCtr 0,1,2,3,4; FetchEn=1.
//  3 LUT[3]=10'd200, in RUN at ProgCtr=7 drive Branch=1, Target=3 -> ProgCtr=200 next cycle, then 201.
//    With PC_BRANCH_COUNT_EN: BranchCount=1.
//  4 At ProgCtr=12 drive Halt=1 and Branch=1 together -> state HALT, ProgCtr stays 12, Done=1, FetchEn=0, no count.
//    Then Start -> ProgCtr=0, Done=0.
//  5 PC_WIDTH=10, branch to LUT entry 10'h3FF, no branch -> ProgCtr 3FF then 000, FetchEn stays 1.
//  6 Same edge: LutWe writes LUT[5]=50 and Branch with Target=5 (old LUT[5]=20) -> ProgCtr=20.
//    Then Reset mid-RUN -> ProgCtr=0, IDLE, FetchEn=0 next cycle.

Source files
------------

// File: rtl/program_counter.sv
// Fetch-side program counter with a loadable branch-target LUT and IDLE/RUN/HALT sequencing.
// Optional taken-branch counter enabled by defining PC_BRANCH_COUNT_EN.
module program_counter #(
   parameter int PC_WIDTH  = 10,
   parameter int LUT_DEPTH = 32
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Halt,
   input  logic                Branch,
   input  logic [4:0]          Target,
   input  logic                LutWe,
   input  logic [4:0]          LutAddr,
   input  logic [PC_WIDTH-1:0] LutData,
   output logic [PC_WIDTH-1:0] ProgCtr,
   output logic                FetchEn,
   output logic                Done,
   output logic [15:0]         BranchCount
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] lut_q [LUT_DEPTH];
   logic [PC_WIDTH-1:0] lut_d [LUT_DEPTH];
   logic [PC_WIDTH-1:0] branch_target;
   logic                target_in_range;
   logic                waddr_in_range;

   assign target_in_range = ({27'd0, Target} < 32'(LUT_DEPTH));
   assign waddr_in_range  = ({27'd0, LutAddr} < 32'(LUT_DEPTH));

   // Reads the pre-write entry so a same-edge write and branch use the old target.
   always_comb begin
      branch_target = '0;
      if (target_in_range) begin
         branch_target = lut_q[Target];
      end
   end

   always_comb begin
      lut_d = lut_q;
      if (LutWe && waddr_in_range) begin
         lut_d[LutAddr] = LutData;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (Start) begin
               state_d = ST_RUN;
               pc_d    = '0;
            end
         end
         ST_RUN: begin
            if (Halt) begin
               state_d = ST_HALT;
            end else if (Branch) begin
               pc_d = branch_target;
            end else begin
               pc_d = pc_q + PC_WIDTH'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         lut_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         lut_q   <= lut_d;
      end
   end

   assign ProgCtr = pc_q;
   assign FetchEn = (state_q == ST_RUN);
   assign Done    = (state_q == ST_HALT);

`ifdef PC_BRANCH_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Cleared when a run launches; saturates rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != ST_RUN) && Start) begin
         cnt_d = '0;
      end else if ((state_q == ST_RUN) && !Halt && Branch && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign BranchCount = cnt_q;
`else
   assign BranchCount = 16'h0000;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a behavioural model predicts each cycle's outputs,
// a monitor pops and compares them after every rising edge.
module tb_program_counter;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Halt;
   logic        Branch;
   logic [4:0]  Target;
   logic        LutWe;
   logic [4:0]  LutAddr;
   logic [9:0]  LutData;
   logic [9:0]  ProgCtr;
   logic        FetchEn;
   logic        Done;
   logic [15:0] BranchCount;

   typedef struct {
      int pc;
      bit fetch;
      bit done;
      int cnt;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model: 0 = idle, 1 = run, 2 = halt.
   int mState;
   int mPc;
   int mCount;
   int mLut[32];

   program_counter #(.PC_WIDTH(10), .LUT_DEPTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Branch(Branch),
      .Target(Target), .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
      .ProgCtr(ProgCtr), .FetchEn(FetchEn), .Done(Done), .BranchCount(BranchCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelStep(input logic rst, input logic st, input logic hl, input logic br,
                            input logic [4:0] tg, input logic we, input logic [4:0] ad,
                            input logic [9:0] dt);
      int oldEntry;
      if (rst) begin
         mState = 0;
         mPc    = 0;
         mCount = 0;
         foreach (mLut[i]) mLut[i] = 0;
      end else begin
         oldEntry = mLut[tg];
         if (mState != 1) begin
            if (st) begin
               mState = 1;
               mPc    = 0;
               mCount = 0;
            end
         end else if (hl) begin
            mState = 2;
         end else if (br) begin
            mPc = oldEntry;
            if (mCount < 65535) mCount++;
         end else begin
            mPc = (mPc + 1) % 1024;
         end
         if (we) mLut[ad] = int'(dt);
      end
   endtask

   // Drives one cycle of inputs, predicts the post-edge outputs, then waits to the falling edge.
   task automatic applyStimulus(input logic rst, input logic st, input logic hl, input logic br,
                                input logic [4:0] tg, input logic we, input logic [4:0] ad,
                                input logic [9:0] dt);
      exp_t e;
      Reset = rst; Start = st; Halt = hl; Branch = br;
      Target = tg; LutWe = we; LutAddr = ad; LutData = dt;
      modelStep(rst, st, hl, br, tg, we, ad, dt);
      e.pc    = mPc;
      e.fetch = (mState == 1);
      e.done  = (mState == 2);
`ifdef PC_BRANCH_COUNT_EN
      e.cnt   = mCount;
`else
      e.cnt   = 0;
`endif
      expQ.push_back(e);
      @(negedge Clk);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 10'd0);
   endtask

   // Monitor: compares every cycle that has a prediction queued.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sb_pc", 32'(ProgCtr), 32'(e.pc));
            checkOutput("sb_fetch", 32'(FetchEn), 32'(e.fetch));
            checkOutput("sb_done", 32'(Done), 32'(e.done));
            checkOutput("sb_count", 32'(BranchCount), 32'(e.cnt));
         end
      end
   end

   initial begin
      // Reset held two cycles, then released.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 10'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 10'd0);
      idleCycle();
      checkOutput("reset_pc", 32'(ProgCtr), 32'd0);
      checkOutput("reset_fetch", 32'(FetchEn), 32'd0);
      checkOutput("reset_done", 32'(Done), 32'd0);
      checkOutput("reset_count", 32'(BranchCount), 32'd0);

      // LUT loads while idle; Halt/Branch must be ignored here.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 10'd200);
      checkOutput("idle_ignores_pc", 32'(ProgCtr), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 10'd20);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 10'h3FF);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 10'd12);

      // Linear fetch after Start.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 10'd0);
      checkOutput("start_pc", 32'(ProgCtr), 32'd0);
      checkOutput("start_fetch", 32'(FetchEn), 32'd1);
      for (int i = 1; i < 5; i++) begin
         idleCycle();
         checkOutput("linear_pc", 32'(ProgCtr), 32'(i));
      end
      for (int k = 0; k < 20 && ProgCtr != 10'd7; k++) idleCycle();
      checkOutput("reach7_pc", 32'(ProgCtr), 32'd7);

      // Absolute branch through LUT[3].
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 10'd0);
      checkOutput("branch_pc", 32'(ProgCtr), 32'd200);
      idleCycle();
      checkOutput("branch_next_pc", 32'(ProgCtr), 32'd201);
`ifdef PC_BRANCH_COUNT_EN
      checkOutput("branch_count", 32'(BranchCount), 32'd1);
`endif

      // Reach 12, then Halt together with Branch: halt wins.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 10'd0);
      checkOutput("to12_pc", 32'(ProgCtr), 32'd12);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 10'd0);
      checkOutput("halt_pc", 32'(ProgCtr), 32'd12);
      checkOutput("halt_done", 32'(Done), 32'd1);
      checkOutput("halt_fetch", 32'(FetchEn), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 10'd0);
      checkOutput("halt_hold_pc", 32'(ProgCtr), 32'd12);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 10'd0);
      checkOutput("restart_pc", 32'(ProgCtr), 32'd0);
      checkOutput("restart_done", 32'(Done), 32'd0);

      // Wrap-around from all-ones.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 10'd0);
      checkOutput("wrap_top_pc", 32'(ProgCtr), 32'h3FF);
      idleCycle();
      checkOutput("wrap_zero_pc", 32'(ProgCtr), 32'd0);
      checkOutput("wrap_fetch", 32'(FetchEn), 32'd1);

      // Same-edge write and branch to entry 5 uses the old value.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 10'd50);
      checkOutput("old_entry_pc", 32'(ProgCtr), 32'd20);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 10'd0);
      checkOutput("new_entry_pc", 32'(ProgCtr), 32'd50);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 10'd0);
      checkOutput("midrun_reset_pc", 32'(ProgCtr), 32'd0);
      checkOutput("midrun_reset_fetch", 32'(FetchEn), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                       5'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom), 10'($urandom));
      end

      idleCycle();
      repeat (3) @(negedge Clk);
      checkOutput("drain_queue", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
